// File: rtl/dmem_responder.sv
// dmem_responder: byte-maskable synchronous word memory with zeroing sweep, write-first forwarding and error pulse
module dmem_responder #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h8000_0000
) (
    input  logic                i_sys_clk,
    input  logic                i_sys_rst,
    input  logic                i_ram_rd_en,
    input  logic [ADDR_W-1:0]   i_ram_rd_addr,
    output logic [DATA_W-1:0]   o_ram_rd_data,
    output logic                o_ram_rd_vld,
    input  logic                i_ram_wr_en,
    input  logic [ADDR_W-1:0]   i_ram_wr_addr,
    input  logic [DATA_W-1:0]   i_ram_wr_data,
    input  logic [DATA_W/8-1:0] i_ram_wr_mask,
    output logic                o_ram_busy,
    output logic                o_ram_err
);
    localparam int NB = DATA_W / 8;
    localparam int LB = $clog2(NB);
    localparam int IW = $clog2(DEPTH);
    typedef enum logic {INIT, READY} state_t;
    state_t state;
    logic [IW-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] rd_off, wr_off;
    logic rd_ok, wr_ok, wr_act;
    logic [IW-1:0] rd_idx, wr_idx;
    logic [DATA_W-1:0] wr_old, wr_merged, rd_word;
    assign rd_off = i_ram_rd_addr - BASE_ADDR;
    assign wr_off = i_ram_wr_addr - BASE_ADDR;
    assign rd_ok = ((rd_off & ADDR_W'(NB - 1)) == '0) && (i_ram_rd_addr >= BASE_ADDR) && ((rd_off >> LB) < ADDR_W'(DEPTH));
    assign wr_ok = ((wr_off & ADDR_W'(NB - 1)) == '0) && (i_ram_wr_addr >= BASE_ADDR) && ((wr_off >> LB) < ADDR_W'(DEPTH));
    assign rd_idx = IW'(rd_off >> LB);
    assign wr_idx = IW'(wr_off >> LB);
    assign wr_act = (state == READY) && i_ram_wr_en && wr_ok;
    assign wr_old = mem[wr_idx];
    assign o_ram_busy = (state == INIT);
    // merge masked write lanes over the stored word; forward it to a same-word read
    always_comb begin
        wr_merged = wr_old;
        for (int k = 0; k < NB; k++)
            wr_merged[8*k +: 8] = i_ram_wr_mask[k] ? i_ram_wr_data[8*k +: 8] : wr_old[8*k +: 8];
        rd_word = (wr_act && wr_idx == rd_idx) ? wr_merged : mem[rd_idx];
    end
    // storage: zeroing sweep during INIT, masked writes afterwards
    always_ff @(posedge i_sys_clk) begin
        if (state == INIT)
            mem[cnt] <= '0;
        else if (wr_act)
            mem[wr_idx] <= wr_merged;
    end
    // control FSM with registered read response and error pulse
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            state <= INIT;
            cnt <= '0;
            o_ram_rd_data <= '0;
            o_ram_rd_vld <= 1'b0;
            o_ram_err <= 1'b0;
        end else if (state == INIT) begin
            cnt <= cnt + 1'b1;
            state <= (cnt == IW'(DEPTH - 1)) ? READY : INIT;
            o_ram_rd_vld <= 1'b0;
            o_ram_err <= 1'b0;
        end else begin
            o_ram_rd_vld <= i_ram_rd_en;
            o_ram_rd_data <= i_ram_rd_en ? (rd_ok ? rd_word : '0) : o_ram_rd_data;
            o_ram_err <= (i_ram_rd_en && !rd_ok) || (i_ram_wr_en && !wr_ok);
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder with DEPTH=16
module tb_dmem_responder;
    localparam logic [31:0] B = 32'h8000_0000;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rd_en = 1'b0, wr_en = 1'b0;
    logic [31:0] rd_addr = '0, wr_addr = '0, wr_data = '0, rd_data;
    logic [3:0] wr_mask = '0;
    logic rd_vld, busy, err;
    int tests = 0, fails = 0, cyc = 0;
    typedef struct {int due; logic vld; logic [31:0] data; logic err;} rsp_t;
    rsp_t q[$];
    logic [31:0] exp_rb [16];

    dmem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(16), .BASE_ADDR(32'h8000_0000)) dut (
        .i_sys_clk(clk), .i_sys_rst(rst),
        .i_ram_rd_en(rd_en), .i_ram_rd_addr(rd_addr), .o_ram_rd_data(rd_data), .o_ram_rd_vld(rd_vld),
        .i_ram_wr_en(wr_en), .i_ram_wr_addr(wr_addr), .i_ram_wr_data(wr_data), .i_ram_wr_mask(wr_mask),
        .o_ram_busy(busy), .o_ram_err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: pops the scoreboard whenever the DUT presents a response or a response is overdue
    always @(negedge clk) begin
        rsp_t e;
        if (rd_vld || err) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_out cyc=%0d vld=%0b err=%0b data=%h, required no output", cyc, rd_vld, err, rd_data);
            end else begin
                e = q.pop_front();
                if (e.due != cyc || rd_vld != e.vld || err != e.err || (e.vld && rd_data != e.data)) begin
                    fails++;
                    $display("FAIL rsp cyc=%0d vld=%0b err=%0b data=%h, required cyc=%0d vld=%0b err=%0b data=%h",
                             cyc, rd_vld, err, rd_data, e.due, e.vld, e.err, e.data);
                end
            end
        end else if (q.size() != 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            tests++;
            fails++;
            $display("FAIL missing_rsp cyc=%0d got no output, required vld=%0b err=%0b data=%h", cyc, e.vld, e.err, e.data);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %h, required %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic re, input logic [31:0] ra, input logic we, input logic [31:0] wa,
                         input logic [31:0] wd, input logic [3:0] wm);
        @(posedge clk);
        #1;
        rd_en = re; rd_addr = ra; wr_en = we; wr_addr = wa; wr_data = wd; wr_mask = wm;
    endtask

    task automatic push(input logic v, input logic [31:0] d, input logic e);
        q.push_back('{cyc + 1, v, d, e});
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic e);
        drive(1'b1, a, 1'b0, '0, '0, '0);
        push(1'b1, d, e);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, input logic e);
        drive(1'b0, '0, 1'b1, a, d, m);
        if (e) push(1'b0, '0, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, 1'b0, '0, '0, '0);
    endtask

    task automatic sweep();
        int n, bad;
        n = 0;
        bad = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        while (busy && n < 100) begin
            n++;
            if (rd_vld || err) bad++;
            @(negedge clk);
        end
        rd_en = 1'b0; wr_en = 1'b0;
        check("busy_cycles", n, 16);
        check("busy_quiet", bad, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_vld", rd_vld, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 1);
        check("rst_data", rd_data, 0);
        rd_en = 1'b1; rd_addr = B + 2;
        wr_en = 1'b1; wr_addr = B; wr_data = 32'hFFFF_FFFF; wr_mask = 4'hF;
        sweep();
        for (int i = 0; i < 16; i++) rd(B + 4 * i, 32'h0, 1'b0);
        wr(B + 8, 32'hDEAD_BEEF, 4'hF, 1'b0);
        wr(B + 8, 32'h0000_1200, 4'b0010, 1'b0);
        rd(B + 8, 32'hDEAD_12EF, 1'b0);
        wr(B + 8, 32'hFFFF_FFFF, 4'h0, 1'b0);
        rd(B + 8, 32'hDEAD_12EF, 1'b0);
        wr(B + 4, 32'h1122_3344, 4'hF, 1'b0);
        drive(1'b1, B + 4, 1'b1, B + 4, 32'hAABB_CCDD, 4'b1100);
        push(1'b1, 32'hAABB_3344, 1'b0);
        rd(B + 4, 32'hAABB_3344, 1'b0);
        idle(1);
        rd(B + 2, 32'h0, 1'b1);
        idle(1);
        rd(32'h7FFF_FFFC, 32'h0, 1'b1);
        wr(B + 64, 32'h1234_5678, 4'hF, 1'b1);
        wr(B + 64, 32'h1234_5678, 4'h0, 1'b1);
        drive(1'b1, B + 8, 1'b1, B + 65, 32'h5555_5555, 4'hF);
        push(1'b1, 32'hDEAD_12EF, 1'b1);
        rd(B + 60, 32'h0, 1'b0);
        exp_rb = '{default: 32'h0};
        exp_rb[1] = 32'hAABB_3344;
        exp_rb[2] = 32'hDEAD_12EF;
        for (int i = 0; i < 16; i++) rd(B + 4 * i, exp_rb[i], 1'b0);
        for (int i = 0; i < 8; i++) wr(B + 4 * i, i + 1, 4'hF, 1'b0);
        for (int i = 0; i < 8; i++) rd(B + 4 * i, i + 1, 1'b0);
        idle(2);
        rd(B, 32'h1, 1'b0);
        rd(B + 4, 32'h2, 1'b0);
        rd(B + 8, 32'h3, 1'b0);
        #2;
        rst = 1'b1;
        q.delete();
        #1;
        check("midrst_vld", rd_vld, 0);
        check("midrst_err", err, 0);
        check("midrst_busy", busy, 1);
        rd_en = 1'b0;
        repeat (2) @(posedge clk);
        sweep();
        for (int i = 0; i < 8; i++) rd(B + 4 * i, 32'h0, 1'b0);
        idle(3);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
